lsu_mem_access: RTL and testbench
=================================

// Module: lsu_mem_access
// PURPOSE
//  Multi-cycle load/store unit between the execute stage and the data memory bus. Accepts one
//  access (addr from alu_out, store data, width 1/2/4, we), drives a word-aligned request with
//  byte strobes, waits for grant/read data, and returns the raw loaded value right-justified
//  in bits [W-1:0]. Execute applies sign/zero extension. One access in flight; no buffering.
// PARAMETERS
//  TIMEOUT_CYC  256  cycles in WAIT without mem_rvalid before aborting with rsp_err
//  CNT_W        9    timeout counter width; must hold TIMEOUT_CYC
// PORTS
//  clk         in   1   single clock, rising edge
//  rst_n       in   1   asynchronous, active-low reset
//  req_valid   in   1   execute offers an access
//  req_ready   out  1   unit idle and able to accept
//  req_we      in   1   1 = store, 0 = load
//  req_addr    in   32  byte address
//  req_wdata   in   32  store data, right-justified
//  req_width   in   32  access size in bytes: 1, 2 or 4; any other value is an error
//  rsp_valid   out  1   one-cycle pulse: access complete
//  rsp_rdata   out  32  load data right-justified, upper bits zero; 0 for stores
//  rsp_err     out  1   qualified by rsp_valid: misaligned, bad width or timeout
//  mem_req     out  1   bus request, held until mem_gnt
//  mem_we      out  1   bus write enable
//  mem_addr    out  32  {req_addr[31:2],2'b00}
//  mem_wdata   out  32  store data replicated into its byte lanes
//  mem_wstrb   out  4   byte-lane strobes; 4'b0000 on loads
//  mem_gnt     in   1   bus accepts request this cycle
//  mem_rvalid  in   1   read data / write ack valid
//  mem_rdata   in   32  full aligned word
// BEHAVIOUR
//  Reset: state=IDLE; req_ready=1; rsp_valid=0; rsp_err=0; rsp_rdata=0; mem_req=0; mem_we=0;
//   mem_addr=0; mem_wdata=0; mem_wstrb=0; timeout counter=0.
//  Request capture: a handshake occurs when req_valid & req_ready. addr, wdata, width and we
//   are registered that cycle. req_ready=1 only in IDLE.
//  FSM:
//   IDLE -> ERR when the captured access is misaligned or has a bad width; no bus activity.
//   IDLE -> REQ otherwise.
//   REQ: mem_req=1 with stable outputs. On mem_gnt, go to WAIT and clear the counter.
//   WAIT: on mem_rvalid, go to RESP and latch the extracted data. Otherwise increment the
//    counter. When counter == TIMEOUT_CYC-1, go to ERR.
//   RESP: rsp_valid=1 and rsp_err=0 for exactly one cycle, then IDLE.
//   ERR: rsp_valid=1, rsp_err=1 and rsp_rdata=0 for exactly one cycle, then IDLE.
//  Latency (no faults): handshake in cycle 0, mem_req in cycle 1. With mem_gnt in cycle 1 and
//   mem_rvalid in cycle 2, rsp_valid is in cycle 3. An error has rsp_valid in cycle 2.
//  Alignment: width 2 requires addr[0]==0. Width 4 requires addr[1:0]==0. Width 1 is always
//   aligned.
//  Strobes: width 1 -> 4'b0001<<addr[1:0]. Width 2 -> 4'b0011<<addr[1:0]. Width 4 -> 4'b1111.
//  wdata lanes: byte {4{wdata[7:0]}}; half {2{wdata[15:0]}}; word wdata.
//  Load extract: rdata>>(8*addr[1:0]), masked to the width. Stores return rsp_rdata=0.
//  Simultaneous events: mem_gnt and mem_rvalid in the same REQ cycle is a protocol violation.
//   Only mem_gnt is honoured.
//  mem_rvalid outside WAIT is ignored.
//  req_valid while busy is not accepted; no stall beyond req_ready=0.
//  rst_n low mid-access returns all state to reset values immediately. No response is emitted
//   for the aborted access.
// STRUCTURE
//  Shared package lsu_pkg: state enum {IDLE,REQ,WAIT,RESP,ERR}; width constants
//   SZ_B=1, SZ_H=2, SZ_W=4.
//  Submodule lsu_lane_align (combinational) computes wstrb, lane-replicated wdata, the
//   misalign flag and load extraction. Top level holds the FSM, capture registers and timeout
//   counter.
// TESTING
//  1. lw addr=0x80000004, gnt cyc1, rvalid cyc2 rdata=0xDEADBEEF -> rsp cyc3, rdata=0xDEADBEEF,
//     err=0.
//  2. sb addr=0x80000003 wdata=0x000000A5 -> mem_wstrb=4'b1000, mem_wdata=0xA5A5A5A5,
//     mem_addr=0x80000000.
//  3. lh addr=0x80000002, rdata=0x8001_7FFF -> rsp_rdata=0x00008001.
//  4. lw addr=0x80000002 or width=3 -> mem_req never asserted; rsp_valid cyc2 with err=1.
//  5. Grant, then no rvalid for TIMEOUT_CYC cycles -> one-cycle rsp_valid with err=1, back to
//     IDLE, req_ready=1.
//  6. rst_n low during WAIT -> outputs at reset values asynchronously; a later rvalid produces
//     no rsp_valid.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
package lsu_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned STRB_W = XLEN / 8;

  localparam logic [XLEN-1:0] SZ_B = 32'd1;
  localparam logic [XLEN-1:0] SZ_H = 32'd2;
  localparam logic [XLEN-1:0] SZ_W = 32'd4;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    RESP,
    ERR
  } lsu_state_e;

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: store strobes/replication, alignment checks and load extraction.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [1:0]        addr_lo,
  input  logic [XLEN-1:0]   width,
  input  logic [XLEN-1:0]   wdata,
  input  logic [XLEN-1:0]   rdata,
  output logic [STRB_W-1:0] wstrb,
  output logic [XLEN-1:0]   wdata_lanes,
  output logic              bad_width,
  output logic              misalign,
  output logic [XLEN-1:0]   load_data
);

  logic [XLEN-1:0] shifted;

  always_comb begin
    shifted     = rdata >> {addr_lo, 3'b000};
    wstrb       = '0;
    wdata_lanes = wdata;
    bad_width   = 1'b0;
    misalign    = 1'b0;
    load_data   = shifted;
    case (width)
      SZ_B: begin
        wstrb       = 4'b0001 << addr_lo;
        wdata_lanes = {4{wdata[7:0]}};
        load_data   = {24'd0, shifted[7:0]};
      end
      SZ_H: begin
        wstrb       = 4'b0011 << addr_lo;
        wdata_lanes = {2{wdata[15:0]}};
        misalign    = addr_lo[0];
        load_data   = {16'd0, shifted[15:0]};
      end
      SZ_W: begin
        wstrb    = 4'b1111;
        misalign = |addr_lo;
      end
      default: bad_width = 1'b1;
    endcase
  end

endmodule

// File: rtl/lsu_mem_access.sv
// Multi-cycle load/store unit: one access in flight between execute and the data bus.
module lsu_mem_access
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 256,
  parameter int unsigned CNT_W       = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [XLEN-1:0]   req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  input  logic [XLEN-1:0]   req_width,
  output logic              rsp_valid,
  output logic [XLEN-1:0]   rsp_rdata,
  output logic              rsp_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [XLEN-1:0]   mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [STRB_W-1:0] mem_wstrb,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [XLEN-1:0]   mem_rdata
);

  lsu_state_e        state, next_state;
  logic [1:0]        addr_lo_q;
  logic [XLEN-1:0]   width_q;
  logic              we_q;
  logic [CNT_W-1:0]  cnt;
  logic              accept;

  logic [1:0]        sel_addr_lo;
  logic [XLEN-1:0]   sel_width;
  logic [STRB_W-1:0] lane_wstrb;
  logic [XLEN-1:0]   lane_wdata;
  logic              bad_width;
  logic              misalign;
  logic [XLEN-1:0]   load_data;

  // Lane logic sees the live request while idle, the captured access otherwise.
  assign sel_addr_lo = (state == IDLE) ? req_addr[1:0] : addr_lo_q;
  assign sel_width   = (state == IDLE) ? req_width     : width_q;
  assign accept      = req_valid & req_ready;

  lsu_lane_align u_lane_align (
    .addr_lo     (sel_addr_lo),
    .width       (sel_width),
    .wdata       (req_wdata),
    .rdata       (mem_rdata),
    .wstrb       (lane_wstrb),
    .wdata_lanes (lane_wdata),
    .bad_width   (bad_width),
    .misalign    (misalign),
    .load_data   (load_data)
  );

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (accept) next_state = (misalign | bad_width) ? ERR : REQ;
      REQ:  if (mem_gnt) next_state = WAIT;
      WAIT: begin
        if (mem_rvalid) next_state = RESP;
        else if (cnt == CNT_W'(TIMEOUT_CYC - 1)) next_state = ERR;
      end
      RESP:    next_state = IDLE;
      ERR:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
      addr_lo_q <= '0;
      width_q   <= '0;
      we_q      <= 1'b0;
      cnt       <= '0;
    end else begin
      state     <= next_state;
      req_ready <= (next_state == IDLE);
      mem_req   <= (next_state == REQ);
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      if (accept) begin
        addr_lo_q <= req_addr[1:0];
        width_q   <= req_width;
        we_q      <= req_we;
      end
      if (accept && next_state == REQ) begin
        mem_we    <= req_we;
        mem_addr  <= {req_addr[XLEN-1:2], 2'b00};
        mem_wdata <= lane_wdata;
        mem_wstrb <= req_we ? lane_wstrb : '0;
      end
      if (state == REQ && mem_gnt) cnt <= '0;
      else if (state == WAIT && !mem_rvalid) cnt <= cnt + CNT_W'(1);
      if (state == WAIT && mem_rvalid) begin
        rsp_valid <= 1'b1;
        rsp_rdata <= we_q ? '0 : load_data;
      end
      if (state == ERR) begin
        rsp_valid <= 1'b1;
        rsp_err   <= 1'b1;
        rsp_rdata <= '0;
      end
    end
  end

endmodule

// File: tb/tb_lsu_mem_access.sv
// Directed self-checking bench for lsu_mem_access.
module tb_lsu_mem_access;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [31:0] req_width = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  lsu_mem_access dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_width  (req_width),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wstrb  (mem_wstrb),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one handshake (cycle 0) and returns at the sample point of cycle 1.
  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] width);
    for (int i = 0; i < 16 && !req_ready; i++) step();
    n_checks++;
    if (req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL issue_ready: req_ready=%b required 1", req_ready);
    end
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_width = width;
    step();
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    n_checks++;
    if ({req_ready, rsp_valid, rsp_err, mem_req, mem_we, mem_wstrb} !== 9'b1_0000_0000 ||
        rsp_rdata !== 32'd0 || mem_addr !== 32'd0 || mem_wdata !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_vals: ready=%b vld=%b err=%b req=%b we=%b strb=%b rdata=%h addr=%h wdata=%h required 1/0/0/0/0/0000/0/0/0",
               req_ready, rsp_valid, rsp_err, mem_req, mem_we, mem_wstrb, rsp_rdata, mem_addr, mem_wdata);
    end
    #10 rst_n = 1'b1;
    step();
  endtask

  task automatic test_load_word();
    issue(1'b0, 32'h8000_0004, 32'h0, 32'd4);
    n_checks++;
    if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h8000_0004 || mem_wstrb !== 4'b0000) begin
      n_fail++;
      $display("FAIL lw_req: req=%b we=%b addr=%h strb=%b required 1/0/80000004/0000", mem_req, mem_we, mem_addr, mem_wstrb);
    end
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    n_checks++;
    if (mem_req !== 1'b0 || rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL lw_wait: req=%b rsp_valid=%b required 0/0", mem_req, rsp_valid);
    end
    step();
    mem_rvalid = 1'b0;
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL lw_rsp: vld=%b err=%b rdata=%h required 1/0/deadbeef", rsp_valid, rsp_err, rsp_rdata);
    end
    step();
    n_checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL lw_pulse: vld=%b ready=%b required 0/1", rsp_valid, req_ready);
    end
  endtask

  task automatic test_store_lanes();
    issue(1'b1, 32'h8000_0003, 32'h0000_00A5, 32'd1);
    n_checks++;
    if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_wstrb !== 4'b1000 ||
        mem_wdata !== 32'hA5A5_A5A5 || mem_addr !== 32'h8000_0000) begin
      n_fail++;
      $display("FAIL sb_bus: req=%b we=%b strb=%b wdata=%h addr=%h required 1/1/1000/a5a5a5a5/80000000",
               mem_req, mem_we, mem_wstrb, mem_wdata, mem_addr);
    end
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
    step();
    mem_rvalid = 1'b0;
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'd0) begin
      n_fail++;
      $display("FAIL sb_rsp: vld=%b err=%b rdata=%h required 1/0/0", rsp_valid, rsp_err, rsp_rdata);
    end
    step();
    issue(1'b1, 32'h8000_0102, 32'h1234_BEEF, 32'd2);
    n_checks++;
    if (mem_wstrb !== 4'b1100 || mem_wdata !== 32'hBEEF_BEEF || mem_addr !== 32'h8000_0100) begin
      n_fail++;
      $display("FAIL sh_bus: strb=%b wdata=%h addr=%h required 1100/beefbeef/80000100", mem_wstrb, mem_wdata, mem_addr);
    end
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0; mem_rvalid = 1'b1;
    step();
    mem_rvalid = 1'b0;
    step();
  endtask

  task automatic test_load_extract();
    issue(1'b0, 32'h8000_0002, 32'h0, 32'd2);
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h8001_7FFF;
    step();
    mem_rvalid = 1'b0;
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0000_8001) begin
      n_fail++;
      $display("FAIL lh_extract: vld=%b rdata=%h required 1/00008001", rsp_valid, rsp_rdata);
    end
    step();
  endtask

  task automatic test_errors();
    logic [31:0] addrs  [2];
    logic [31:0] widths [2];
    addrs[0] = 32'h8000_0002; widths[0] = 32'd4;
    addrs[1] = 32'h8000_0000; widths[1] = 32'd3;
    for (int k = 0; k < 2; k++) begin
      issue(1'b0, addrs[k], 32'h0, widths[k]);
      n_checks++;
      if (mem_req !== 1'b0 || rsp_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL err%0d_cyc1: req=%b vld=%b required 0/0", k, mem_req, rsp_valid);
      end
      step();
      n_checks++;
      if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_rdata !== 32'd0 || mem_req !== 1'b0) begin
        n_fail++;
        $display("FAIL err%0d_cyc2: vld=%b err=%b rdata=%h req=%b required 1/1/0/0", k, rsp_valid, rsp_err, rsp_rdata, mem_req);
      end
      step();
      n_checks++;
      if (rsp_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL err%0d_pulse: vld=%b required 0", k, rsp_valid);
      end
    end
  endtask

  task automatic test_timeout();
    int  cyc;
    bit  seen;
    cyc  = 2;
    seen = 1'b0;
    issue(1'b0, 32'h8000_0008, 32'h0, 32'd4);
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    while (!seen && cyc < 400) begin
      if (rsp_valid === 1'b1) seen = 1'b1;
      else begin
        step();
        cyc++;
      end
    end
    n_checks++;
    if (!seen || cyc != 259) begin
      n_fail++;
      $display("FAIL timeout_cycle: seen=%b cycle=%0d required 1/259", seen, cyc);
    end
    n_checks++;
    if (rsp_err !== 1'b1 || rsp_rdata !== 32'd0) begin
      n_fail++;
      $display("FAIL timeout_rsp: err=%b rdata=%h required 1/0", rsp_err, rsp_rdata);
    end
    step();
    n_checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_idle: vld=%b ready=%b required 0/1", rsp_valid, req_ready);
    end
  endtask

  task automatic test_reset_mid_access();
    issue(1'b1, 32'h8000_0010, 32'hCAFE_F00D, 32'd4);
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({req_ready, rsp_valid, mem_req, mem_we, mem_wstrb} !== 8'b1000_0000 ||
        mem_addr !== 32'd0 || mem_wdata !== 32'd0) begin
      n_fail++;
      $display("FAIL async_reset: ready=%b vld=%b req=%b we=%b strb=%b addr=%h wdata=%h required 1/0/0/0/0000/0/0",
               req_ready, rsp_valid, mem_req, mem_we, mem_wstrb, mem_addr, mem_wdata);
    end
    @(posedge clk);
    #3 rst_n = 1'b1;
    step();
    mem_rvalid = 1'b1; mem_rdata = 32'h5555_AAAA;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if (rsp_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL stale_rvalid%0d: vld=%b required 0", i, rsp_valid);
      end
    end
    mem_rvalid = 1'b0;
  endtask

  task automatic test_back_to_back();
    issue(1'b0, 32'h8000_0001, 32'h0, 32'd1);
    mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    step();
    mem_gnt = 1'b0; mem_rdata = 32'h1122_3344;
    n_checks++;
    if (rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL gnt_rvalid_req: vld=%b required 0", rsp_valid);
    end
    step();
    mem_rvalid = 1'b0;
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0000_0033) begin
      n_fail++;
      $display("FAIL lb_extract: vld=%b rdata=%h required 1/00000033", rsp_valid, rsp_rdata);
    end
    step();
    issue(1'b0, 32'h8000_0020, 32'h0, 32'd4);
    n_checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h8000_0020) begin
      n_fail++;
      $display("FAIL b2b_req: req=%b addr=%h required 1/80000020", mem_req, mem_addr);
    end
    step();
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0BAD_F00D;
    step();
    mem_rvalid = 1'b0;
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0BAD_F00D) begin
      n_fail++;
      $display("FAIL b2b_rsp: vld=%b err=%b rdata=%h required 1/0/0badf00d", rsp_valid, rsp_err, rsp_rdata);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_load_word();
    test_store_lanes();
    test_load_extract();
    test_errors();
    test_timeout();
    test_reset_mid_access();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
